// File: rtl/key_event_gen_if.sv
// key_event_gen_if: raw active-low key levels in, conditioned per-key levels and event pulses out.
// The master drives the keys (board / testbench); key_event_gen is the slave.
interface key_event_gen_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] i_key;
  logic [N_KEYS-1:0] o_held;
  logic [N_KEYS-1:0] o_short;
  logic [N_KEYS-1:0] o_long;

  modport master (output i_key, input o_held, o_short, o_long);
  modport slave  (input i_key, output o_held, o_short, o_long);
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: per-key 2-flop synchroniser, debouncer and short/long press classifier.
// Define KEY_AUTOREPEAT_EN to repeat o_long every REPEAT_CYCLES while a long press is held.
module key_event_gen #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  key_event_gen_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_LONG,
    S_REL_DB
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_KEYS-1:0] key_p;
  logic [N_KEYS-1:0] ret_long_q, ret_long_d;
  logic [N_KEYS-1:0] held_q, held_d, short_q, short_d, long_q, long_d;

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [DW-1:0]     dcnt_q  [N_KEYS];
  logic [DW-1:0]     dcnt_d  [N_KEYS];
  logic [HW-1:0]     hcnt_q  [N_KEYS];
  logic [HW-1:0]     hcnt_d  [N_KEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0]     rcnt_q  [N_KEYS];
  logic [RW-1:0]     rcnt_d  [N_KEYS];
`else
  // The repeat period only matters when auto-repeat is built in.
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES != 0);
`endif

  assign sync1_d = bus.i_key;
  assign sync2_d = sync1_q;
  assign key_p   = ~sync2_q;

  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      // NOTE: every output of this block gets a default first so no path leaves a latch.
      state_d[k]    = state_q[k];
      dcnt_d[k]     = dcnt_q[k];
      hcnt_d[k]     = hcnt_q[k];
      ret_long_d[k] = ret_long_q[k];
      short_d[k]    = 1'b0;
      long_d[k]     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_d[k]     = rcnt_q[k];
`endif

      unique case (state_q[k])
        S_IDLE: begin
          if (key_p[k]) begin
            state_d[k] = S_PRESS_DB;
            dcnt_d[k]  = '0;
          end
        end
        S_PRESS_DB: begin
          if (!key_p[k]) begin
            state_d[k] = S_IDLE;
          end else if (dcnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_d[k] = S_HELD;
            hcnt_d[k]  = '0;
          end else begin
            dcnt_d[k]  = dcnt_q[k] + DW'(1);
          end
        end
        S_HELD: begin
          if (!key_p[k]) begin
            state_d[k]    = S_REL_DB;
            dcnt_d[k]     = '0;
            ret_long_d[k] = 1'b0;
          end else if (hcnt_q[k] == HW'(LONG_CYCLES - 1)) begin
            state_d[k] = S_LONG;
            long_d[k]  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d[k]  = '0;
`endif
          end else begin
            hcnt_d[k]  = hcnt_q[k] + HW'(1);
          end
        end
        S_LONG: begin
          if (!key_p[k]) begin
            state_d[k]    = S_REL_DB;
            dcnt_d[k]     = '0;
            ret_long_d[k] = 1'b1;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rcnt_q[k] == RW'(REPEAT_CYCLES - 1)) begin
            long_d[k] = 1'b1;
            rcnt_d[k] = '0;
          end else begin
            rcnt_d[k] = rcnt_q[k] + RW'(1);
          end
`endif
        end
        S_REL_DB: begin
          // A bounce resumes the press; hcnt/rcnt were left untouched while releasing.
          if (key_p[k]) begin
            state_d[k] = ret_long_q[k] ? S_LONG : S_HELD;
          end else if (dcnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_d[k] = S_IDLE;
            short_d[k] = !ret_long_q[k];
          end else begin
            dcnt_d[k]  = dcnt_q[k] + DW'(1);
          end
        end
        default: state_d[k] = S_IDLE;
      endcase

      held_d[k] = (state_d[k] == S_HELD) || (state_d[k] == S_LONG) ||
                  (state_d[k] == S_REL_DB);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: synchronisers reset to 1 (released) so a key held through reset is re-debounced.
      sync1_q    <= '1;
      sync2_q    <= '1;
      ret_long_q <= '0;
      held_q     <= '0;
      short_q    <= '0;
      long_q     <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= S_IDLE;
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q[k]  <= '0;
`endif
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      ret_long_q <= ret_long_d;
      held_q     <= held_d;
      short_q    <= short_d;
      long_q     <= long_d;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q[k]  <= rcnt_d[k];
`endif
      end
    end
  end

  assign bus.o_held  = held_q;
  assign bus.o_short = short_q;
  assign bus.o_long  = long_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed scenarios plus random key traffic against a run-length reference model.
// Honours KEY_AUTOREPEAT_EN the same way the design does.
module tb_key_event_gen;

  localparam int N_KEYS = 3;
  localparam int DB     = 4;
  localparam int LG     = 20;
  localparam int RP     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;

  key_event_gen_if #(.N_KEYS(N_KEYS)) bus ();

  key_event_gen #(
    .N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference model: a press is accepted after DB+1 consecutive sampled-pressed edges and
  // released after DB+1 consecutive sampled-released edges; hold time counts pressed edges
  // that continue an already-pressed run.
  logic [N_KEYS-1:0] exp_held = '0, exp_short = '0, exp_long = '0;
  logic kd0 [N_KEYS], kd1 [N_KEYS], last_p [N_KEYS], pressed [N_KEYS], fired [N_KEYS];
  int   run [N_KEYS], hold_n [N_KEYS], rep_n [N_KEYS];

  always @(posedge clk) begin
    logic p;
    edge_n++;
    for (int k = 0; k < N_KEYS; k++) begin
      exp_short[k] = 1'b0;
      exp_long[k]  = 1'b0;
      if (rst) begin
        kd0[k] = 1'b1; kd1[k] = 1'b1; last_p[k] = 1'b0; run[k] = 0;
        pressed[k] = 1'b0; fired[k] = 1'b0; hold_n[k] = 0; rep_n[k] = 0;
      end else begin
        p      = ~kd1[k];
        kd1[k] = kd0[k];
        kd0[k] = bus.i_key[k];
        run[k] = (p == last_p[k]) ? run[k] + 1 : 1;
        last_p[k] = p;
        if (!pressed[k]) begin
          if (p && run[k] == DB + 1) begin
            pressed[k] = 1'b1; fired[k] = 1'b0; hold_n[k] = 0; rep_n[k] = 0;
          end
        end else if (!p) begin
          if (run[k] == DB + 1) begin
            pressed[k]   = 1'b0;
            exp_short[k] = !fired[k];
          end
        end else if (run[k] >= 2) begin
          if (!fired[k]) begin
            hold_n[k]++;
            if (hold_n[k] == LG) begin
              exp_long[k] = 1'b1; fired[k] = 1'b1; rep_n[k] = 0;
            end
          end
`ifdef KEY_AUTOREPEAT_EN
          else begin
            rep_n[k]++;
            if (rep_n[k] == RP) begin
              exp_long[k] = 1'b1; rep_n[k] = 0;
            end
          end
`endif
        end
      end
      exp_held[k] = pressed[k];
    end
  end

  // Monitor: compares every cycle and keeps per-key event statistics for directed checks.
  int   short_cnt [N_KEYS], long_cnt [N_KEYS], rise_cnt [N_KEYS];
  int   held_rise [N_KEYS], first_long [N_KEYS], last_short [N_KEYS];
  logic held_prev [N_KEYS];

  initial for (int k = 0; k < N_KEYS; k++) held_prev[k] = 1'b0;

  always @(negedge clk) begin
    check("held",  32'(bus.o_held),  32'(exp_held));
    check("short", 32'(bus.o_short), 32'(exp_short));
    check("long",  32'(bus.o_long),  32'(exp_long));
    for (int k = 0; k < N_KEYS; k++) begin
      if (bus.o_short[k]) begin
        short_cnt[k]++;
        last_short[k] = edge_n;
      end
      if (bus.o_long[k]) begin
        long_cnt[k]++;
        if (first_long[k] == 0) first_long[k] = edge_n;
      end
      if (bus.o_held[k] && !held_prev[k]) begin
        rise_cnt[k]++;
        if (held_rise[k] == 0) held_rise[k] = edge_n;
      end
      held_prev[k] = bus.o_held[k];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < N_KEYS; k++) begin
      short_cnt[k] = 0; long_cnt[k] = 0; rise_cnt[k] = 0;
      held_rise[k] = 0; first_long[k] = 0; last_short[k] = 0;
    end
  endtask

  initial begin
    int t0, tr, lc;
    logic [N_KEYS-1:0] kv;
    int rem [N_KEYS];

    // Reset with all keys pressed.
    bus.i_key = 3'b000;
    rst = 1'b1;
    tick(3);
    check("rst_held", 32'(bus.o_held), 0);
    check("rst_pulses", 32'(bus.o_short | bus.o_long), 0);
    rst = 1'b0;
    clr();
    t0 = edge_n + 1;
    tick(12);
    for (int k = 0; k < N_KEYS; k++) check("rst_rise", held_rise[k], t0 + 6);
    check("rst_no_pulse", short_cnt[0] + short_cnt[1] + short_cnt[2] +
                          long_cnt[0] + long_cnt[1] + long_cnt[2], 0);
    bus.i_key = 3'b111;
    tick(30);

    // Short press on key 1.
    clr();
    t0 = edge_n + 1;
    bus.i_key = 3'b101;
    tick(10);
    bus.i_key = 3'b111;
    tr = edge_n + 1;
    tick(20);
    check("short_rise", held_rise[1], t0 + 6);
    check("short_cnt", short_cnt[1], 1);
    check("short_time", last_short[1], tr + 6);
    check("short_nolong", long_cnt[1], 0);

    // Bounces shorter than the debounce window.
    clr();
    bus.i_key = 3'b110; tick(3);
    bus.i_key = 3'b111; tick(2);
    bus.i_key = 3'b110; tick(3);
    bus.i_key = 3'b111; tick(20);
    check("bounce_rise", rise_cnt[0], 0);
    check("bounce_short", short_cnt[0], 0);
    clr();
    bus.i_key = 3'b110; tick(8);
    bus.i_key = 3'b111; tick(1);
    bus.i_key = 3'b110; tick(1);
    bus.i_key = 3'b111; tick(1);
    bus.i_key = 3'b110; tick(1);
    bus.i_key = 3'b111; tick(20);
    check("glitch_short", short_cnt[0], 1);
    check("glitch_rise", rise_cnt[0], 1);

    // Long press on key 2.
    clr();
    t0 = edge_n + 1;
    bus.i_key = 3'b011;
    tick(44);
    bus.i_key = 3'b111;
    tick(20);
`ifdef KEY_AUTOREPEAT_EN
    lc = 3;
`else
    lc = 1;
`endif
    check("long_rise", held_rise[2], t0 + 6);
    check("long_first", first_long[2], t0 + 26);
    check("long_cnt", long_cnt[2], lc);
    check("long_noshort", short_cnt[2], 0);

    // Keys 0 and 1 together.
    clr();
    bus.i_key = 3'b100;
    tick(10);
    bus.i_key = 3'b111;
    tick(20);
    check("simul_cnt0", short_cnt[0], 1);
    check("simul_cnt1", short_cnt[1], 1);
    check("simul_same", last_short[0], last_short[1]);
    check("simul_key2", rise_cnt[2] + short_cnt[2] + long_cnt[2], 0);

    // Reset in the middle of a key 2 press.
    clr();
    bus.i_key = 3'b011;
    tick(15);
    rst = 1'b1;
    tick(1);
    check("midrst_held", 32'(bus.o_held[2]), 0);
    tick(1);
    rst = 1'b0;
    check("midrst_nolong", long_cnt[2], 0);
    clr();
    t0 = edge_n + 1;
    tick(30);
    check("midrst_rise", held_rise[2], t0 + 6);
    check("midrst_long", first_long[2], t0 + 26);
    bus.i_key = 3'b111;
    tick(20);

    // Random traffic: mixed bounce, short and long runs per key, occasional reset.
    for (int k = 0; k < N_KEYS; k++) rem[k] = 0;
    kv = 3'b111;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (rem[k] == 0) begin
          kv[k]  = ~kv[k];
          rem[k] = kv[k] ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 45));
        end
        rem[k]--;
      end
      bus.i_key = kv;
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    bus.i_key = 3'b111;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
